dmem_arbiter: RTL

Two-port arbiter sharing the single-ported 128×16 data memory (`mem`) between the CPU load/store path (port 0) and a debug/loader requester (port 1, e.g. a UART program loader). It uses a valid/ready request handshake with round-robin priority. It absorbs the memory's one-cycle synchronous read latency and returns read data with an `rvalid` pulse to the owning port. It sits between the requesters and the `mem` instance, and drives all of `mem`'s write and read controls.

---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_arbiter_if.sv | 57 +++++
 rtl/dmem_arbiter_rr_arb2.sv | 42 ++++
 rtl/dmem_arbiter.sv | 105 ++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port indices
// and default bus widths.
package dmem_pkg;

    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 16;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester, response, memory-side and debug signals of the data-memory
// arbiter. The slave modport is the arbiter's view; master is the environment's.
interface dmem_arbiter_if
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    // Handshake: a request is accepted in the cycle where reqN_valid && reqN_ready;
    // the requester holds valid/we/addr/wdata stable until then. rspN_rvalid is a
    // single-cycle pulse and rspN_rdata is meaningful only while it is high.
    logic              req0_valid;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ready;
    logic              req1_valid;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ready;

    logic              rsp0_rvalid;
    logic [DATA_W-1:0] rsp0_rdata;
    logic              rsp1_rvalid;
    logic [DATA_W-1:0] rsp1_rdata;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_w_addr;
    logic [ADDR_W-1:0] mem_r_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;

    state_e            dbg_state;
    logic              dbg_last_gnt;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req0_ready, req1_ready,
        output rsp0_rvalid, rsp0_rdata, rsp1_rvalid, rsp1_rdata,
        output mem_we, mem_w_addr, mem_r_addr, mem_data_in,
        input  mem_data_out,
        output dbg_state, dbg_last_gnt
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req0_ready, req1_ready,
        input  rsp0_rvalid, rsp0_rdata, rsp1_rvalid, rsp1_rdata,
        input  mem_we, mem_w_addr, mem_r_addr, mem_data_in,
        output mem_data_out,
        input  dbg_state, dbg_last_gnt
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick. On contention the port that did not win the most
// recent accepted request is granted; last_gnt resets to 1 so port 0 wins first.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] valid,
    output logic [1:0] gnt,
    output logic       winner,
    output logic       last_gnt
);

    logic last_gnt_q;
    logic last_gnt_d;

    always_comb begin
        winner = 1'b0;
        if (valid == 2'b11) begin
            winner = ~last_gnt_q;
        end else if (valid[1]) begin
            winner = 1'b1;
        end

        gnt = 2'b00;
        if (en && (valid != 2'b00)) begin
            gnt = winner ? 2'b10 : 2'b01;
        end

        last_gnt_d = (gnt != 2'b00) ? winner : last_gnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

    assign last_gnt = last_gnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the CPU (port 0) and a debug
// loader (port 1), absorbing the memory's one-cycle registered read latency.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    state_e            state_q, state_d;
    logic              rd_owner_q, rd_owner_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [ADDR_W-1:0] r_addr_q, r_addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [1:0]        gnt;
    logic              winner;
    logic              last_gnt;
    logic              accept;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              rd_done;

    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .rst      (rst),
        .en       (state_q == ST_IDLE),
        .valid    ({bus.req1_valid, bus.req0_valid}),
        .gnt      (gnt),
        .winner   (winner),
        .last_gnt (last_gnt)
    );

    always_comb begin
        accept    = (gnt != 2'b00);
        sel_we    = (winner == PORT_DBG) ? bus.req1_we    : bus.req0_we;
        sel_addr  = (winner == PORT_DBG) ? bus.req1_addr  : bus.req0_addr;
        sel_wdata = (winner == PORT_DBG) ? bus.req1_wdata : bus.req0_wdata;

        state_d    = state_q;
        rd_owner_d = rd_owner_q;
        w_addr_d   = w_addr_q;
        r_addr_d   = r_addr_q;
        wdata_d    = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (sel_we) begin
                        w_addr_d = sel_addr;
                        wdata_d  = sel_wdata;
                    end else begin
                        r_addr_d   = sel_addr;
                        rd_owner_d = winner;
                        state_d    = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rd_owner_q <= PORT_CPU;
            w_addr_q   <= '0;
            r_addr_q   <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            rd_owner_q <= rd_owner_d;
            w_addr_q   <= w_addr_d;
            r_addr_q   <= r_addr_d;
            wdata_q    <= wdata_d;
        end
    end

    // Memory controls come from the next-value of the hold registers, so an
    // accept shows up this cycle and otherwise the last driven value stays put.
    assign bus.mem_we      = accept && sel_we;
    assign bus.mem_w_addr  = w_addr_d;
    assign bus.mem_r_addr  = r_addr_d;
    assign bus.mem_data_in = wdata_d;

    // A reset landing on the response cycle discards the in-flight read.
    assign rd_done         = (state_q == ST_RD_WAIT) && !rst;
    assign bus.rsp0_rvalid = rd_done && (rd_owner_q == PORT_CPU);
    assign bus.rsp1_rvalid = rd_done && (rd_owner_q == PORT_DBG);
    assign bus.rsp0_rdata  = bus.rsp0_rvalid ? bus.mem_data_out : '0;
    assign bus.rsp1_rdata  = bus.rsp1_rvalid ? bus.mem_data_out : '0;

    assign bus.req0_ready  = gnt[0];
    assign bus.req1_ready  = gnt[1];

    assign bus.dbg_state    = state_q;
    assign bus.dbg_last_gnt = last_gnt;

endmodule
